data_ram_responder: RTL and testbench

//   Memory-side responder for the core's fetch and load/store ports. Word-addressed

---
 rtl/data_ram_responder.sv | 181 ++++++++++++++++++
 tb/tb_data_ram_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// data_ram_responder: word-addressed RAM serving the core's 1-cycle fetch port and a
// wait-stated, byte-enable data port whose read path is paced by a small FSM.
module data_ram_responder #(
    parameter int    ADDR_WIDTH  = 31,
    parameter int    DATA_WIDTH  = 31,
    parameter int    DEPTH_LOG2  = 12,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
    output logic [DATA_WIDTH:0]   o_read_fetch_data,
    input  logic                  i_read_req,
    input  logic [ADDR_WIDTH:0]   i_read_addr,
    output logic [DATA_WIDTH:0]   o_read_data,
    output logic                  o_read_ready,
    input  logic                  i_write_enable,
    input  logic [3:0]            i_byte_enable,
    input  logic [ADDR_WIDTH:0]   i_write_addr,
    input  logic [DATA_WIDTH:0]   i_write_data,
    output logic                  o_addr_fault
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VALID} state_t;

    logic [DATA_WIDTH:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH:0] addr);
        return (addr >> DEPTH_LOG2) == '0;
    endfunction

    function automatic logic [DATA_WIDTH:0] merge_lanes(input logic [DATA_WIDTH:0] old_word,
                                                        input logic [3:0]          be,
                                                        input logic [DATA_WIDTH:0] new_word);
        logic [DATA_WIDTH:0] w;
        w = old_word;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) w[8*n +: 8] = new_word[8*n +: 8];
        end
        return w;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] ca_q, ca_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH:0] rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic [DATA_WIDTH:0] fetch_q, fetch_d;

    logic                  wr_ok;
    logic                  launch;
    logic [DEPTH_LOG2-1:0] wr_idx, fetch_idx, req_idx, ca_idx;
    logic [DATA_WIDTH:0]   fetch_word, req_word, ca_word;

    assign wr_ok     = i_write_enable && in_range(i_write_addr);
    assign wr_idx    = i_write_addr[DEPTH_LOG2-1:0];
    assign fetch_idx = i_read_fetch_addr[DEPTH_LOG2-1:0];
    assign req_idx   = i_read_addr[DEPTH_LOG2-1:0];
    assign ca_idx    = ca_q[DEPTH_LOG2-1:0];

    // Write-first bypass: any read of the word being written sees the merged new value.
    always_comb begin
        fetch_word = '0;
        req_word   = '0;
        ca_word    = '0;
        if (in_range(i_read_fetch_addr)) begin
            fetch_word = mem[fetch_idx];
            if (wr_ok && wr_idx == fetch_idx)
                fetch_word = merge_lanes(fetch_word, i_byte_enable, i_write_data);
        end
        if (in_range(i_read_addr)) begin
            req_word = mem[req_idx];
            if (wr_ok && wr_idx == req_idx)
                req_word = merge_lanes(req_word, i_byte_enable, i_write_data);
        end
        if (in_range(ca_q)) begin
            ca_word = mem[ca_idx];
            if (wr_ok && wr_idx == ca_idx)
                ca_word = merge_lanes(ca_word, i_byte_enable, i_write_data);
        end
    end

    always_comb begin
        state_d = state_q;
        ca_d    = ca_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        fetch_d = fetch_word;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                if (i_read_req) launch = 1'b1;
            end
            ST_WAIT: begin
                ready_d = 1'b0;
                if (!i_read_req) begin
                    state_d = ST_IDLE;
                end else if (i_read_addr != ca_q) begin
                    launch = 1'b1;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = '0;
                    rdata_d = ca_word;
                    ready_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!i_read_req) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end else if (i_read_addr != ca_q) begin
                    launch = 1'b1;
                end else begin
                    rdata_d = ca_word;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
        // The counter holds the wait cycles still to elapse, so the read lands after 1+WAIT_STATES edges.
        if (launch) begin
            ca_d = i_read_addr;
            if (WAIT_STATES == 0) begin
                cnt_d   = '0;
                rdata_d = req_word;
                ready_d = 1'b1;
                state_d = ST_VALID;
            end else begin
                cnt_d   = WAIT_LOAD;
                ready_d = 1'b0;
                state_d = ST_WAIT;
            end
        end
        fault_d = (i_write_enable && !in_range(i_write_addr)) ||
                  (launch && !in_range(i_read_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ca_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            fetch_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            ca_q    <= ca_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            fetch_q <= fetch_d;
        end
    end

    // RAM contents survive reset, so the array sits outside the reset domain.
    always_ff @(posedge clk) begin
        if (clk_en && wr_ok) mem[wr_idx] <= merge_lanes(mem[wr_idx], i_byte_enable, i_write_data);
    end

    assign o_read_fetch_data = fetch_q;
    assign o_read_data       = rdata_q;
    assign o_read_ready      = ready_q;
    assign o_addr_fault      = fault_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios plus a randomized run,
// all compared against a word-array reference model with a request-age read rule.
module tb_data_ram_responder;

    localparam int AW    = 31;
    localparam int DW    = 31;
    localparam int DL    = 12;
    localparam int WS    = 3;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [31:0] faddr;
    logic [31:0] fetch_data;
    logic        req;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        rready;
    logic        we;
    logic [3:0]  be;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        fault;

    data_ram_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .WAIT_STATES(WS),
        .INIT_FILE  ("")
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .i_read_fetch_addr(faddr),
        .o_read_fetch_data(fetch_data),
        .i_read_req       (req),
        .i_read_addr      (raddr),
        .o_read_data      (rdata),
        .o_read_ready     (rready),
        .i_write_enable   (we),
        .i_byte_enable    (be),
        .i_write_addr     (waddr),
        .i_write_data     (wdata),
        .o_addr_fault     (fault)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array, plus how many enabled edges the current request has aged.
    logic [31:0] mem_m [DEPTH];
    int          run;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [31:0] exp_fetch;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_fault;
    int          n_vec;
    int          n_err;

    function automatic logic inr(input logic [31:0] a);
        return (a >> DL) == '0;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'(DEPTH + $urandom_range(0, 3));
            2:       return $urandom;
            default: return 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic model_reset();
        exp_fetch = '0;
        exp_rdata = '0;
        exp_ready = 1'b0;
        exp_fault = 1'b0;
        run       = 0;
        prev_req  = 1'b0;
        prev_addr = '0;
    endtask

    task automatic cycle();
        logic launch;
        @(posedge clk);
        if (rst_n && clk_en) begin
            if (we && inr(waddr)) begin
                for (int n = 0; n < 4; n++)
                    if (be[n]) mem_m[waddr[DL-1:0]][8*n +: 8] = wdata[8*n +: 8];
            end
            exp_fetch = inr(faddr) ? mem_m[faddr[DL-1:0]] : 32'h0;
            launch    = req && (!prev_req || raddr != prev_addr);
            if (!req)        run = 0;
            else if (launch) run = 1;
            else if (run < 1000) run = run + 1;
            prev_req  = req;
            prev_addr = raddr;
            exp_ready = (run >= WS + 1);
            if (exp_ready) exp_rdata = inr(raddr) ? mem_m[raddr[DL-1:0]] : 32'h0;
            exp_fault = (we && !inr(waddr)) || (launch && !inr(raddr));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0;
        faddr = 32'h5; raddr = '0; waddr = '0; wdata = '0;
        model_reset();
        repeat (3) cycle();
        n_vec++; if (fetch_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_fetch: got %h want 0", fetch_data); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        n_vec++; if (rready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 0", rready); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic fill_memory();
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; be = 4'hf; waddr = 32'(i); wdata = $urandom;
            faddr = 32'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        we = 1'b0; be = 4'h0;
        cycle();
    endtask

    task automatic test_fetch_write();
        we = 1'b1; be = 4'hf; waddr = 32'h5; wdata = 32'hDEADBEEF; faddr = 32'h5;
        cycle();
        we = 1'b0;
        n_vec++; if (fetch_data !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL fetch_write_first: got %h want DEADBEEF", fetch_data); end
        cycle();
        n_vec++; if (fetch_data !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL fetch_word5: got %h want DEADBEEF", fetch_data); end
        faddr = 32'h0000_1005;
        cycle();
        n_vec++; if (fetch_data !== 32'h0) begin n_err++; $display("[TB] FAIL fetch_out_of_range: got %h want 0", fetch_data); end
        for (int i = 0; i < 6; i++) begin
            faddr = 32'($urandom_range(0, 31));
            we = 1'($urandom); be = 4'($urandom); waddr = 32'($urandom_range(8, 31)); wdata = $urandom;
            cycle();
            n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL fetch_random: got %h want %h", fetch_data, exp_fetch); end
        end
        we = 1'b0;
    endtask

    task automatic test_byte_enable();
        bit seen;
        we = 1'b1; waddr = 32'h5; be = 4'b0001; wdata = 32'h000000AA;
        cycle();
        be = 4'b0100; wdata = 32'h00CC0000;
        cycle();
        we = 1'b0; req = 1'b1; raddr = 32'h5;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = rready;
        end
        n_vec++; if (!seen) begin n_err++; $display("[TB] FAIL be_ready_timeout: got ready 0 want 1"); end
        n_vec++; if (rdata !== 32'hDECCBEAA) begin n_err++; $display("[TB] FAIL be_merge: got %h want DECCBEAA", rdata); end
        req = 1'b0;
        cycle();
    endtask

    task automatic test_wait_states();
        req = 1'b0;
        cycle();
        req = 1'b1; raddr = 32'h7;
        for (int c = 1; c <= 5; c++) begin
            cycle();
            n_vec++; if (rready !== (c >= 4)) begin n_err++; $display("[TB] FAIL wait_ready_c%0d: got %b want %b", c, rready, c >= 4); end
            if (c >= 4) begin
                n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("[TB] FAIL wait_data_c%0d: got %h want %h", c, rdata, exp_rdata); end
            end
        end
    endtask

    task automatic test_valid_tracking();
        we = 1'b1; be = 4'hf; waddr = 32'h7; wdata = 32'h12345678;
        cycle();
        we = 1'b0;
        n_vec++; if (rdata !== 32'h12345678) begin n_err++; $display("[TB] FAIL valid_track_data: got %h want 12345678", rdata); end
        n_vec++; if (rready !== 1'b1) begin n_err++; $display("[TB] FAIL valid_track_ready: got %b want 1", rready); end
        we = 1'b1; be = 4'b1010; wdata = $urandom;
        cycle();
        we = 1'b0;
        n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("[TB] FAIL valid_track_partial: got %h want %h", rdata, exp_rdata); end
        req = 1'b0;
        cycle();
        n_vec++; if (rready !== 1'b0) begin n_err++; $display("[TB] FAIL valid_drop_ready: got %b want 0", rready); end
    endtask

    task automatic test_out_of_range();
        bit seen;
        req = 1'b1; raddr = 32'(DEPTH);
        cycle();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("[TB] FAIL oor_read_fault: got %b want 1", fault); end
        cycle();
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL oor_read_fault_pulse: got %b want 0", fault); end
        seen = rready;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = rready;
        end
        n_vec++; if (!seen) begin n_err++; $display("[TB] FAIL oor_ready_timeout: got ready 0 want 1"); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL oor_read_data: got %h want 0", rdata); end
        req = 1'b0;
        cycle();
        we = 1'b1; be = 4'hf; waddr = 32'(DEPTH); wdata = ~mem_m[0]; faddr = 32'h0;
        cycle();
        we = 1'b0;
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("[TB] FAIL oor_write_fault: got %b want 1", fault); end
        n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL oor_write_word0: got %h want %h", fetch_data, exp_fetch); end
        cycle();
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL oor_write_fault_pulse: got %b want 0", fault); end
        n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL oor_word0_after: got %h want %h", fetch_data, exp_fetch); end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        req = 1'b1; raddr = 32'h9;
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (rready !== 1'b0) begin n_err++; $display("[TB] FAIL midwait_reset_ready: got %b want 0", rready); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL midwait_reset_rdata: got %h want 0", rdata); end
        cycle();
        rst_n = 1'b1; req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++; if (rready !== 1'b0) begin n_err++; $display("[TB] FAIL midwait_stale_ready: got %b want 0", rready); end
        end
        req = 1'b1; raddr = 32'h9; faddr = 32'h9;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = rready;
        end
        n_vec++; if (!seen) begin n_err++; $display("[TB] FAIL hold_ready_timeout: got ready 0 want 1"); end
        clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; be = 4'hf; waddr = 32'h9; wdata = $urandom;
            raddr = pick_addr(); faddr = pick_addr(); req = 1'($urandom);
            cycle();
            n_vec++; if (rready !== exp_ready) begin n_err++; $display("[TB] FAIL hold_ready: got %b want %b", rready, exp_ready); end
            n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("[TB] FAIL hold_rdata: got %h want %h", rdata, exp_rdata); end
            n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL hold_fetch: got %h want %h", fetch_data, exp_fetch); end
            n_vec++; if (fault !== exp_fault) begin n_err++; $display("[TB] FAIL hold_fault: got %b want %b", fault, exp_fault); end
        end
        clk_en = 1'b1; we = 1'b0; req = 1'b0; faddr = 32'h9;
        cycle();
        n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL hold_no_write: got %h want %h", fetch_data, exp_fetch); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) req = ~req;
            if ($urandom_range(0, 6) == 0) raddr = pick_addr();
            we    = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 1) == 0) ? raddr : pick_addr();
            be    = 4'($urandom);
            wdata = $urandom;
            faddr = ($urandom_range(0, 1) == 0) ? raddr : pick_addr();
            cycle();
            n_vec++; if (fetch_data !== exp_fetch) begin n_err++; $display("[TB] FAIL rand_fetch@%0d: got %h want %h", i, fetch_data, exp_fetch); end
            n_vec++; if (rready !== exp_ready) begin n_err++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", i, rready, exp_ready); end
            if (exp_ready) begin
                n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("[TB] FAIL rand_rdata@%0d: got %h want %h", i, rdata, exp_rdata); end
            end
            n_vec++; if (fault !== exp_fault) begin n_err++; $display("[TB] FAIL rand_fault@%0d: got %b want %b", i, fault, exp_fault); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        fill_memory();
        test_fetch_write();
        test_byte_enable();
        test_wait_states();
        test_valid_tracking();
        test_out_of_range();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
